// File: rtl/text_pkg.sv
// Shared text-overlay definitions.
// Used by the character overlay, the channel formatters and the text RAM
// write scheduler. Holds the text RAM geometry and the scheduler state
// encodings.
package text_pkg;

    localparam int unsigned TEXT_ADDR_W = 8;   // 256-entry text RAM
    localparam int unsigned CHAR_W      = 7;   // 7-bit character codes
    localparam int unsigned TEXT_COLS   = 16;
    localparam int unsigned TEXT_ROWS   = 16;

    // Write scheduler states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req - request vector
//   ptr - index where the search starts (highest priority this round)
//   gnt - one-hot grant, all zero when no request is active
//   idx - index of the granted requester (0 when none)
// The search walks upward from ptr modulo NREQ. The pointer register lives
// in the parent.
module rr_arbiter #(
    parameter int unsigned NREQ  = 13,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/text_ram_write_scheduler.sv
// Text RAM write scheduler.
// Shares the single text RAM write port among NREQ channel formatters and a
// full-screen clear. Writes are issued only while vblnk_in is high.
// Ports:
//   pclk      - pixel clock, rising edge
//   rst       - asynchronous active-low reset
//   vblnk_in  - vertical blanking; a write may happen only when high
//   clr_req   - one-cycle pulse requesting a full-screen clear
//   req       - per-requester request level
//   req_xy    - per-requester start address {row,col}, 8 bits each
//   req_data  - per-requester CHARS character codes, 7 bits each
//   gnt       - one-hot one-cycle acceptance pulse
//   busy      - burst or clear pending/in progress
//   clr_busy  - clear latched and not yet finished
//   wr_en, wr_addr, wr_data - text RAM write port
module text_ram_write_scheduler
    import text_pkg::*;
#(
    parameter int unsigned       NREQ     = 13,
    parameter int unsigned       CHARS    = 4,
    parameter logic [CHAR_W-1:0] CLR_CODE = 7'h20
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic                        vblnk_in,
    input  logic                        clr_req,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*8-1:0]           req_xy,
    input  logic [NREQ*CHARS*CHAR_W-1:0] req_data,
    output logic [NREQ-1:0]             gnt,
    output logic                        busy,
    output logic                        clr_busy,
    output logic                        wr_en,
    output logic [TEXT_ADDR_W-1:0]      wr_addr,
    output logic [CHAR_W-1:0]           wr_data
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned K_W   = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(CHARS - 1);

    logic [1:0]               state, state_nxt;
    logic                     clr_pend, pend_nxt;
    logic [IDX_W-1:0]         ptr;
    logic [K_W-1:0]           k;
    logic [TEXT_ADDR_W-1:0]   xy_lat;
    logic [TEXT_ADDR_W-1:0]   clr_addr;
    logic [CHARS*CHAR_W-1:0]  data_lat;
    logic [NREQ-1:0]          arb_gnt;
    logic [IDX_W-1:0]         arb_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    // clr_pend already tracks "latched until the last clear write"
    assign clr_busy = clr_pend;

    // Next state and clear-pending; busy is registered from these so that it
    // matches (state != IDLE) | clr_pend in the same cycle.
    always_comb begin
        state_nxt = state;
        pend_nxt  = clr_pend;
        if (clr_req && state != ST_CLEAR)
            pend_nxt = 1'b1;
        case (state)
            ST_IDLE: begin
                if (clr_pend)
                    state_nxt = ST_CLEAR;
                else if (|req)
                    state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (vblnk_in && k == K_LAST)
                    state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (vblnk_in && clr_addr == '1) begin
                    state_nxt = ST_IDLE;
                    pend_nxt  = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            clr_pend <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            k        <= '0;
            xy_lat   <= '0;
            data_lat <= '0;
            clr_addr <= '0;
            gnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            clr_pend <= pend_nxt;
            busy     <= (state_nxt != ST_IDLE) | pend_nxt;
            gnt      <= '0;
            wr_en    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_pend) begin
                        clr_addr <= '0;
                    end else if (|req) begin
                        gnt      <= arb_gnt;
                        xy_lat   <= req_xy[int'(arb_idx)*8 +: 8];
                        data_lat <= req_data[int'(arb_idx)*CHARS*CHAR_W +: CHARS*CHAR_W];
                        k        <= '0;
                        ptr      <= (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (vblnk_in) begin
                        wr_en   <= 1'b1;
                        wr_addr <= xy_lat + TEXT_ADDR_W'(k);
                        wr_data <= data_lat[int'(k)*CHAR_W +: CHAR_W];
                        k       <= k + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (vblnk_in) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= clr_addr;
                        wr_data  <= CLR_CODE;
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
